// File: rtl/axi_lite_scratchpad_arbiter_if.sv
// AXI4-Lite master-side bundle for the scratchpad arbiter.
// master modport: arbiter drives AW/W/AR valids, addresses, write data, B/R readies.
// slave modport : scratchpad drives readies, B/R responses and read data.
interface axi_lite_scratchpad_arbiter_if #(
    parameter int unsigned ADDR_W_p = 4
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = 2;

    logic [ADDR_W_p-1:0] o_axi_awaddr;
    logic                o_axi_awvalid;
    logic                i_axi_awready;
    logic [DATA_W-1:0]   o_axi_wdata;
    logic [STRB_W-1:0]   o_axi_wstrb;
    logic                o_axi_wvalid;
    logic                i_axi_wready;
    logic [RESP_W-1:0]   i_axi_bresp;
    logic                i_axi_bvalid;
    logic                o_axi_bready;
    logic [ADDR_W_p-1:0] o_axi_araddr;
    logic                o_axi_arvalid;
    logic                i_axi_arready;
    logic [DATA_W-1:0]   i_axi_rdata;
    logic [RESP_W-1:0]   i_axi_rresp;
    logic                i_axi_rvalid;
    logic                o_axi_rready;

    modport master (
        output o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wstrb, o_axi_wvalid,
        output o_axi_bready, o_axi_araddr, o_axi_arvalid, o_axi_rready,
        input  i_axi_awready, i_axi_wready, i_axi_bresp, i_axi_bvalid,
        input  i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rvalid
    );

    modport slave (
        input  o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wstrb, o_axi_wvalid,
        input  o_axi_bready, o_axi_araddr, o_axi_arvalid, o_axi_rready,
        output i_axi_awready, i_axi_wready, i_axi_bresp, i_axi_bvalid,
        output i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rvalid
    );
endinterface

// File: rtl/axi_lite_scratchpad_arbiter.sv
// Two-requester round-robin arbiter in front of an AXI4-Lite scratchpad.
// One transaction outstanding at a time; completion signalled by a one-cycle o_ack.
// Ports: clk, rst_n (async, active-low); i_req/i_we/i_addr/i_wdata/i_wstrb per requester;
//        o_ack/o_rdata/o_resp completion; axi = AXI4-Lite master bundle.
module axi_lite_scratchpad_arbiter #(
    parameter int unsigned ADDR_W_p = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              i_req,
    input  logic [1:0]              i_we,
    input  logic [2*ADDR_W_p-1:0]   i_addr,
    input  logic [63:0]             i_wdata,
    input  logic [7:0]              i_wstrb,
    output logic [1:0]              o_ack,
    output logic [31:0]             o_rdata,
    output logic [1:0]              o_resp,
    axi_lite_scratchpad_arbiter_if.master axi
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned NREQ   = 2;

    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                rr_q, rr_d;
    logic [ADDR_W_p-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                bready_q, bready_d, rready_q, rready_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [RESP_W-1:0]   resp_q, resp_d;

    logic                win;
    logic                sel_we;
    logic [ADDR_W_p-1:0] sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;

    // Winner pick: on a tie the requester not served last goes first.
    always_comb begin
        win       = 1'b0;
        if (i_req == 2'b11) win = ~rr_q;
        else                win = i_req[1];
        sel_we    = win ? i_we[1]                        : i_we[0];
        sel_addr  = win ? i_addr[ADDR_W_p +: ADDR_W_p]   : i_addr[0 +: ADDR_W_p];
        sel_wdata = win ? i_wdata[DATA_W +: DATA_W]      : i_wdata[0 +: DATA_W];
        sel_wstrb = win ? i_wstrb[STRB_W +: STRB_W]      : i_wstrb[0 +: STRB_W];
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        case (state_q)
            IDLE: begin
                // The ack cycle blocks a grant so the just-served requester can drop i_req.
                if ((|i_req) && !(|ack_q)) begin
                    gnt_d = win;
                    if (sel_we) begin
                        state_d   = WRITE;
                        awaddr_d  = sel_addr;
                        wdata_d   = sel_wdata;
                        wstrb_d   = sel_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        araddr_d  = sel_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; leave once neither is pending.
                awvalid_d = awvalid_q && !axi.i_axi_awready;
                wvalid_d  = wvalid_q && !axi.i_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi.i_axi_bvalid) begin
                    state_d  = IDLE;
                    bready_d = 1'b0;
                    ack_d    = gnt_q ? 2'b10 : 2'b01;
                    resp_d   = axi.i_axi_bresp;
                    rr_d     = gnt_q;
                end
            end
            READ: begin
                if (axi.i_axi_arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (axi.i_axi_rvalid) begin
                    state_d  = IDLE;
                    rready_d = 1'b0;
                    ack_d    = gnt_q ? 2'b10 : 2'b01;
                    resp_d   = axi.i_axi_rresp;
                    rdata_d  = axi.i_axi_rdata;
                    rr_d     = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            rr_q      <= 1'b1;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign o_ack             = ack_q;
    assign o_rdata           = rdata_q;
    assign o_resp            = resp_q;
    assign axi.o_axi_awaddr  = awaddr_q;
    assign axi.o_axi_awvalid = awvalid_q;
    assign axi.o_axi_wdata   = wdata_q;
    assign axi.o_axi_wstrb   = wstrb_q;
    assign axi.o_axi_wvalid  = wvalid_q;
    assign axi.o_axi_bready  = bready_q;
    assign axi.o_axi_araddr  = araddr_q;
    assign axi.o_axi_arvalid = arvalid_q;
    assign axi.o_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_scratchpad_arbiter.sv
// Directed bench for axi_lite_scratchpad_arbiter with a small behavioural scratchpad slave.
module tb_axi_lite_scratchpad_arbiter;
    localparam int unsigned ADDR_W = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  i_req;
    logic [1:0]  i_we;
    logic [7:0]  i_addr;
    logic [63:0] i_wdata;
    logic [7:0]  i_wstrb;
    logic [1:0]  o_ack;
    logic [31:0] o_rdata;
    logic [1:0]  o_resp;

    axi_lite_scratchpad_arbiter_if #(.ADDR_W_p(ADDR_W)) axi ();

    axi_lite_scratchpad_arbiter #(.ADDR_W_p(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_we    (i_we),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .i_wstrb (i_wstrb),
        .o_ack   (o_ack),
        .o_rdata (o_rdata),
        .o_resp  (o_resp),
        .axi     (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave model configuration and observation.
    int          aw_delay = 0;
    int          b_delay  = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] mem [4];
    logic [3:0]  aw_addr_s;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;
    logic [3:0]  ar_addr_s;
    int          ar_hs = 0;
    int          ack_total = 0;

    // Scratchpad slave: decides readies/responses on the falling edge.
    initial begin
        int   aw_cnt;
        int   b_cnt;
        logic aw_got, w_got, ar_got;
        for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + 32'(i);
        aw_cnt = 0; b_cnt = 0; aw_got = 0; w_got = 0; ar_got = 0;
        aw_addr_s = '0; w_data_s = '0; w_strb_s = '0; ar_addr_s = '0;
        axi.i_axi_awready = 0; axi.i_axi_wready = 0; axi.i_axi_bvalid = 0;
        axi.i_axi_bresp = 0;   axi.i_axi_arready = 0; axi.i_axi_rvalid = 0;
        axi.i_axi_rresp = 0;   axi.i_axi_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.i_axi_awready = 0; axi.i_axi_wready = 0; axi.i_axi_bvalid = 0;
                axi.i_axi_arready = 0; axi.i_axi_rvalid = 0;
                aw_cnt = 0; b_cnt = 0; aw_got = 0; w_got = 0; ar_got = 0;
                continue;
            end
            if (axi.o_axi_awvalid && !aw_got) begin
                if (aw_cnt >= aw_delay) begin
                    axi.i_axi_awready = 1; aw_addr_s = axi.o_axi_awaddr; aw_got = 1;
                end else begin
                    axi.i_axi_awready = 0;
                end
                aw_cnt++;
            end else begin
                axi.i_axi_awready = 0; aw_cnt = 0;
            end
            if (axi.o_axi_wvalid && !w_got) begin
                axi.i_axi_wready = 1; w_data_s = axi.o_axi_wdata; w_strb_s = axi.o_axi_wstrb; w_got = 1;
            end else begin
                axi.i_axi_wready = 0;
            end
            if (axi.i_axi_bvalid) begin
                axi.i_axi_bvalid = 0;
            end else if (axi.o_axi_bready && aw_got && w_got) begin
                if (b_cnt >= b_delay) begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb_s[b]) mem[aw_addr_s[3:2]][b*8 +: 8] = w_data_s[b*8 +: 8];
                    axi.i_axi_bvalid = 1; axi.i_axi_bresp = bresp_cfg;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end else begin
                    b_cnt++;
                end
            end
            if (axi.o_axi_arvalid && !ar_got) begin
                axi.i_axi_arready = 1; ar_addr_s = axi.o_axi_araddr; ar_got = 1; ar_hs++;
            end else begin
                axi.i_axi_arready = 0;
            end
            if (axi.i_axi_rvalid) begin
                axi.i_axi_rvalid = 0;
            end else if (axi.o_axi_rready && ar_got) begin
                axi.i_axi_rvalid = 1; axi.i_axi_rdata = mem[ar_addr_s[3:2]];
                axi.i_axi_rresp = rresp_cfg; ar_got = 0;
            end
        end
    end

    // Ack pulse counter.
    initial forever begin
        @(posedge clk); #1;
        if (|o_ack) ack_total++;
    end

    // Results of the last do_txn.
    logic [1:0]  t_ack;
    logic [31:0] t_rdata;
    logic [1:0]  t_resp;
    int          t_lat, t_aw_cyc, t_w_cyc, t_aw_unstable;

    task automatic do_txn(input int r, input logic we, input logic [3:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic drop_early);
        logic [3:0] aw_first;
        aw_first = '0;
        t_ack = '0; t_rdata = '0; t_resp = '0; t_lat = 0;
        t_aw_cyc = 0; t_w_cyc = 0; t_aw_unstable = 0;
        i_we[r] = we;
        i_addr[r*4 +: 4] = addr;
        i_wdata[r*32 +: 32] = data;
        i_wstrb[r*4 +: 4] = strb;
        i_req[r] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (drop_early && c == 0) begin
                i_req[r] = 1'b0;
                i_addr[r*4 +: 4] = ~addr;
                i_wdata[r*32 +: 32] = ~data;
                i_we[r] = ~we;
            end
            if (axi.o_axi_awvalid) begin
                t_aw_cyc++;
                if (t_aw_cyc == 1) aw_first = axi.o_axi_awaddr;
                else if (axi.o_axi_awaddr != aw_first) t_aw_unstable++;
            end
            if (axi.o_axi_wvalid) t_w_cyc++;
            if (|o_ack) begin
                t_ack = o_ack; t_rdata = o_rdata; t_resp = o_resp; t_lat = c + 1;
                i_req[r] = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        chk("ack_one_cycle", 64'(o_ack), 64'h0);
    endtask

    // Both requesters read at once; log completion order and data.
    task automatic do_pair(input string tag);
        logic [1:0]  order [2];
        logic [31:0] data  [2];
        int          n;
        n = 0;
        order[0] = '0; order[1] = '0; data[0] = '0; data[1] = '0;
        i_we = 2'b00;
        i_addr = {4'h8, 4'h0};
        i_req = 2'b11;
        for (int c = 0; c < 100 && n < 2; c++) begin
            @(posedge clk); #1;
            if (|o_ack) begin
                order[n] = o_ack; data[n] = o_rdata; n++;
                i_req = i_req & ~o_ack;
            end
        end
        i_req = 2'b00;
        chk({tag, "_first"},  64'(order[0]), 64'h1);
        chk({tag, "_second"}, 64'(order[1]), 64'h2);
        chk({tag, "_rdata0"}, 64'(data[0]),  64'h1000_0000);
        chk({tag, "_rdata1"}, 64'(data[1]),  64'h1000_0002);
        @(posedge clk); #1;
    endtask

    initial begin
        int ack_before, ar_before;
        i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0; i_wstrb = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",     64'(o_ack),             64'h0);
        chk("rst_rdata",   64'(o_rdata),           64'h0);
        chk("rst_resp",    64'(o_resp),            64'h0);
        chk("rst_valids",  64'({axi.o_axi_awvalid, axi.o_axi_wvalid, axi.o_axi_arvalid}), 64'h0);
        chk("rst_readies", 64'({axi.o_axi_bready, axi.o_axi_rready}), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie straight out of reset, then again: 0 then 1 both times.
        do_pair("rr1");
        do_pair("rr2");

        // Write then read back through requester 0.
        do_txn(0, 1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF, 1'b0);
        chk("w_ack",    64'(t_ack),     64'h1);
        chk("w_resp",   64'(t_resp),    64'h0);
        chk("w_lat",    64'(t_lat),     64'd3);
        chk("w_awaddr", 64'(aw_addr_s), 64'h4);
        chk("w_wdata",  64'(w_data_s),  64'hDEAD_BEEF);
        do_txn(0, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0);
        chk("r_ack",    64'(t_ack),     64'h1);
        chk("r_rdata",  64'(t_rdata),   64'hDEAD_BEEF);
        chk("r_lat",    64'(t_lat),     64'd3);

        // AW stalled three cycles, W immediate, DECERR write response.
        aw_delay = 3; bresp_cfg = 2'b11;
        ack_before = ack_total;
        do_txn(0, 1'b1, 4'h8, 32'h1234_5678, 4'h3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_ack",      64'(t_ack),                  64'h1);
        chk("stall_aw_cyc",   64'(t_aw_cyc),               64'd4);
        chk("stall_w_cyc",    64'(t_w_cyc),                64'd1);
        chk("stall_awaddr",   64'(t_aw_unstable),          64'd0);
        chk("stall_lat",      64'(t_lat),                  64'd6);
        chk("stall_resp",     64'(t_resp),                 64'h3);
        chk("stall_rdata",    64'(t_rdata),                64'hDEAD_BEEF);
        chk("stall_ack_cnt",  64'(ack_total - ack_before), 64'd1);
        aw_delay = 0; bresp_cfg = 2'b00;
        do_txn(1, 1'b0, 4'h8, 32'h0, 4'h0, 1'b0);
        chk("strb_ack",   64'(t_ack),   64'h2);
        chk("strb_rdata", 64'(t_rdata), 64'h1000_5678);

        // SLVERR read, requester drops i_req and scrambles inputs right after grant.
        rresp_cfg = 2'b10;
        ack_before = ack_total; ar_before = ar_hs;
        do_txn(0, 1'b0, 4'h4, 32'h0, 4'h0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("err_ack",     64'(t_ack),                  64'h1);
        chk("err_resp",    64'(t_resp),                 64'h2);
        chk("err_rdata",   64'(t_rdata),                64'hDEAD_BEEF);
        chk("err_ar_cnt",  64'(ar_hs - ar_before),      64'd1);
        chk("err_ack_cnt", 64'(ack_total - ack_before), 64'd1);
        rresp_cfg = 2'b00;

        // Reset while waiting for B.
        b_delay = 5;
        i_we[1] = 1'b1; i_addr[7:4] = 4'hC; i_wdata[63:32] = 32'hCAFE_F00D; i_wstrb[7:4] = 4'hF;
        i_req[1] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (axi.o_axi_bready) break;
        end
        chk("mid_bready", 64'(axi.o_axi_bready), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_valids",  64'({axi.o_axi_awvalid, axi.o_axi_wvalid, axi.o_axi_arvalid}), 64'h0);
        chk("mid_readies", 64'({axi.o_axi_bready, axi.o_axi_rready}), 64'h0);
        chk("mid_ack",     64'(o_ack),   64'h0);
        chk("mid_rdata",   64'(o_rdata), 64'h0);
        chk("mid_resp",    64'(o_resp),  64'h0);
        i_req = 2'b00;
        b_delay = 0;
        ack_before = ack_total;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_no_ack", 64'(ack_total - ack_before), 64'd0);
        do_txn(1, 1'b0, 4'h8, 32'h0, 4'h0, 1'b0);
        chk("post_ack",   64'(t_ack),   64'h2);
        chk("post_rdata", 64'(t_rdata), 64'h1000_5678);
        chk("post_resp",  64'(t_resp),  64'h0);
        chk("post_lat",   64'(t_lat),   64'd3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
